// File: rtl/st7735_spi_receiver.sv
// Purpose : ST7735 4-wire serial bus decoder (CS/DC/LCD_CLK/MOSI -> tagged bytes).
// Latency : byte completes SYNC_STAGES+1 cycles after its 8th LCD_CLK rise; visible on BYTE_OUT 1 cycle later.
// Backpres: BYTE_VALID/BYTE_READY; bytes arriving to a full FIFO are dropped and flagged on OVERFLOW.
//
// Ports:
//   SYSTEM_CLK, RESET_N            clock (>= 4x LCD_CLK), async active-low reset
//   CS, DC, LCD_CLK, MOSI          raw bus inputs, oversampled and synchronized here
//   BYTE_OUT/BYTE_IS_DATA/BYTE_INDEX, BYTE_VALID, BYTE_READY   FIFO head and handshake
//   LAST_CMD                       most recent command byte
//   FRAME_ERR                      one-cycle pulse when CS rises mid-byte
//   OVERFLOW, CLEAR                sticky drop flag and its synchronous clear

// Purpose : generic single-clock FIFO used for the decoded byte queue.
// Latency : write visible on rd_dat/rd_vld the cycle after it is accepted.
// Backpres: wr_rdy low only when full and the head is not being popped in the same cycle.
module st7735_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign rd_vld = (count != '0);
  // A pop in the same cycle frees the slot being written, so full+pop still accepts.
  assign wr_rdy = (count != (AW+1)'(DEPTH)) || rd_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module st7735_spi_receiver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       SYSTEM_CLK,
  input  logic       RESET_N,
  input  logic       CS,
  input  logic       DC,
  input  logic       LCD_CLK,
  input  logic       MOSI,
  output logic [7:0] BYTE_OUT,
  output logic       BYTE_IS_DATA,
  output logic [7:0] BYTE_INDEX,
  output logic       BYTE_VALID,
  input  logic       BYTE_READY,
  output logic [7:0] LAST_CMD,
  output logic       FRAME_ERR,
  output logic       OVERFLOW,
  input  logic       CLEAR
);
  typedef struct packed {
    logic [7:0] dat;
    logic       is_data;
    logic [7:0] idx;
  } entry_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchronizers: bit 0 takes the pin, top bit is the synchronized value.
  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, dc_sync, mosi_sync;
  logic cs_s, clk_s, dc_s, mosi_s;
  logic cs_q, clk_q, cs_rise, clk_rise;

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      clk_sync  <= '1;
      dc_sync   <= '0;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      clk_q     <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], LCD_CLK};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      cs_q      <= cs_s;
      clk_q     <= clk_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_rise  = cs_s && !cs_q;
  assign clk_rise = clk_s && !clk_q;

  // Receive FSM
  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       shift_en, byte_done, frame_err_set;

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!cs_s)  state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CS high gates off every LCD_CLK edge, so shifting and CS rise are exclusive.
  always_comb begin
    shift_en      = (state == SHIFT) && !cs_s && clk_rise;
    byte_done     = shift_en && (bit_cnt == 3'd7);
    frame_err_set = (state == SHIFT) && cs_rise && (bit_cnt != 3'd0);
  end

  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt   <= '0;
      shift     <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= frame_err_set;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (cs_rise) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift   <= {shift[5:0], mosi_s};
      end
    end
  end

  // Byte classification
  logic [7:0] rx_byte, param_cnt, param_nxt;
  entry_t     wr_entry, rd_entry;
  logic       fifo_wr_rdy;

  assign rx_byte   = {shift, mosi_s};
  assign param_nxt = (param_cnt == 8'hFF) ? 8'hFF : param_cnt + 8'd1;

  always_comb begin
    wr_entry.dat     = rx_byte;
    wr_entry.is_data = dc_s;
    wr_entry.idx     = dc_s ? param_nxt : 8'd0;
  end

  // LAST_CMD and the parameter counter track every completed byte, dropped or not.
  always_ff @(posedge SYSTEM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      LAST_CMD  <= '0;
      param_cnt <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (byte_done) begin
        if (dc_s) begin
          param_cnt <= param_nxt;
        end else begin
          LAST_CMD  <= rx_byte;
          param_cnt <= '0;
        end
      end
      // A fresh overflow outranks CLEAR.
      if (byte_done && !fifo_wr_rdy) OVERFLOW <= 1'b1;
      else if (CLEAR)                OVERFLOW <= 1'b0;
    end
  end

  st7735_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (SYSTEM_CLK),
    .rst_n  (RESET_N),
    .wr_vld (byte_done),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (wr_entry),
    .rd_vld (BYTE_VALID),
    .rd_rdy (BYTE_READY),
    .rd_dat (rd_entry)
  );

  assign BYTE_OUT     = rd_entry.dat;
  assign BYTE_IS_DATA = rd_entry.is_data;
  assign BYTE_INDEX   = rd_entry.idx;
endmodule

// File: tb/tb_st7735_spi_receiver.sv
// Purpose : scoreboard bench for st7735_spi_receiver; bit-bangs the ST7735 bus at SYSTEM_CLK/8.
// Latency : expectations queued at send time, compared when the DUT hands a byte over.
// Backpres: BYTE_READY driven per scenario; the reference model predicts drops and OVERFLOW.
module tb_st7735_spi_receiver;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;

  logic       SYSTEM_CLK, RESET_N, CS, DC, LCD_CLK, MOSI, BYTE_READY, CLEAR;
  logic [7:0] BYTE_OUT, BYTE_INDEX, LAST_CMD;
  logic       BYTE_IS_DATA, BYTE_VALID, FRAME_ERR, OVERFLOW;

  st7735_spi_receiver #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .SYSTEM_CLK   (SYSTEM_CLK),
    .RESET_N      (RESET_N),
    .CS           (CS),
    .DC           (DC),
    .LCD_CLK      (LCD_CLK),
    .MOSI         (MOSI),
    .BYTE_OUT     (BYTE_OUT),
    .BYTE_IS_DATA (BYTE_IS_DATA),
    .BYTE_INDEX   (BYTE_INDEX),
    .BYTE_VALID   (BYTE_VALID),
    .BYTE_READY   (BYTE_READY),
    .LAST_CMD     (LAST_CMD),
    .FRAME_ERR    (FRAME_ERR),
    .OVERFLOW     (OVERFLOW),
    .CLEAR        (CLEAR)
  );

  initial SYSTEM_CLK = 1'b0;
  always #5 SYSTEM_CLK = ~SYSTEM_CLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  m_pcnt, m_last;
  bit          m_ovf;
  int          fe_count = 0;
  int          fe_long  = 0;
  logic        fe_prev  = 1'b0;

  // Consumer-side scoreboard: a handshake seen here is accepted on the next rising edge.
  always @(negedge SYSTEM_CLK) begin
    if (FRAME_ERR && !fe_prev) fe_count++;
    if (FRAME_ERR && fe_prev)  fe_long++;
    fe_prev = FRAME_ERR;
    if (RESET_N && BYTE_VALID && BYTE_READY) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte got %h/%b/%0d required none", BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX} !== e) begin
          n_fail++;
          $display("FAIL fifo_entry got %h/%b/%0d required %h/%b/%0d",
                   BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX, e[16:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge SYSTEM_CLK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
    for (int i = 7; i > 7 - n; i--) begin
      LCD_CLK = 1'b0; MOSI = b[i]; DC = dc;
      tick(4);
      LCD_CLK = 1'b1;
      tick(4);
    end
  endtask

  // Reference model of classification and drop, then the bus transfer itself.
  task automatic send_byte(input logic [7:0] b, input logic dc);
    logic [7:0] idx;
    if (!dc) begin
      m_last = b; m_pcnt = 8'd0; idx = 8'd0;
    end else begin
      if (m_pcnt != 8'hFF) m_pcnt = m_pcnt + 8'd1;
      idx = m_pcnt;
    end
    if (!BYTE_READY && exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back({b, dc, idx});
    send_bits(b, 8, dc);
  endtask

  task automatic cs_low();
    CS = 1'b0; tick(4);
  endtask

  task automatic cs_high();
    tick(4); CS = 1'b1; tick(6);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !BYTE_VALID) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; CS = 1'b1; DC = 1'b0; LCD_CLK = 1'b1; MOSI = 1'b0;
    BYTE_READY = 1'b1; CLEAR = 1'b0;
    m_pcnt = 8'd0; m_last = 8'd0; m_ovf = 1'b0;
    tick(3);
    n_checks++;
    if ({BYTE_VALID, BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_fifo_out got %b/%h/%b/%h required 0", BYTE_VALID, BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX);
    end
    n_checks++;
    if ({LAST_CMD, FRAME_ERR, OVERFLOW} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_status got %h/%b/%b required 0", LAST_CMD, FRAME_ERR, OVERFLOW);
    end
    RESET_N = 1'b1;
    tick(4);
  endtask

  task automatic test_single_cmd();
    bit ok;
    int fe0 = fe_count;
    cs_low(); send_byte(8'h11, 1'b0); cs_high();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_drain got %0d pending required 0", exp_q.size()); end
    n_checks++;
    if (LAST_CMD !== 8'h11) begin n_fail++; $display("FAIL single_last_cmd got %h required 11", LAST_CMD); end
    n_checks++;
    if (fe_count != fe0) begin n_fail++; $display("FAIL single_frame_err got %0d pulses required 0", fe_count - fe0); end
  endtask

  task automatic test_cmd_params();
    bit ok;
    cs_low();
    send_byte(8'hB1, 1'b0); send_byte(8'h01, 1'b1); send_byte(8'h2C, 1'b1); send_byte(8'h2D, 1'b1);
    cs_high();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL params_drain got %0d pending required 0", exp_q.size()); end
    n_checks++;
    if (LAST_CMD !== 8'hB1) begin n_fail++; $display("FAIL params_last_cmd got %h required b1", LAST_CMD); end
  endtask

  task automatic test_split_frames();
    bit ok;
    cs_low(); send_byte(8'h2A, 1'b0); cs_high();
    cs_low();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h81, 1'b1);
    cs_high();
    cs_low(); send_byte(8'h2C, 1'b0); send_byte(8'hF8, 1'b1); cs_high();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL split_drain got %0d pending required 0", exp_q.size()); end
    n_checks++;
    if (LAST_CMD !== 8'h2C) begin n_fail++; $display("FAIL split_last_cmd got %h required 2c", LAST_CMD); end
  endtask

  task automatic test_abort();
    bit ok;
    int fe0 = fe_count;
    int fl0 = fe_long;
    cs_low(); send_bits(8'hA5, 5, 1'b0); cs_high();
    n_checks++;
    if (fe_count != fe0 + 1) begin n_fail++; $display("FAIL abort_pulses got %0d required 1", fe_count - fe0); end
    n_checks++;
    if (fe_long != fl0) begin n_fail++; $display("FAIL abort_pulse_width got %0d extra cycles required 0", fe_long - fl0); end
    n_checks++;
    if (BYTE_VALID !== 1'b0) begin n_fail++; $display("FAIL abort_no_push got %b required 0", BYTE_VALID); end
    cs_low(); send_byte(8'h29, 1'b0); cs_high();
    drain(ok);
    n_checks++;
    if (!ok || LAST_CMD !== 8'h29) begin
      n_fail++; $display("FAIL abort_recover got %h pending %0d required 29", LAST_CMD, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] head;
    BYTE_READY = 1'b0;
    cs_low();
    send_byte(8'hC0, 1'b0); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'hC1, 1'b0);
    cs_high();
    head = exp_q[0][16:9];
    n_checks++;
    if (OVERFLOW !== m_ovf) begin n_fail++; $display("FAIL bp_overflow got %b required %b", OVERFLOW, m_ovf); end
    n_checks++;
    if (BYTE_VALID !== 1'b1 || BYTE_OUT !== head) begin
      n_fail++; $display("FAIL bp_head_held got %b/%h required 1/%h", BYTE_VALID, BYTE_OUT, head);
    end
    n_checks++;
    if (LAST_CMD !== m_last) begin n_fail++; $display("FAIL bp_last_cmd got %h required %h", LAST_CMD, m_last); end
    CLEAR = 1'b1; tick(1); CLEAR = 1'b0; tick(1);
    m_ovf = 1'b0;
    n_checks++;
    if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL bp_clear got %b required 0", OVERFLOW); end
    BYTE_READY = 1'b1;
    drain(ok);
    // The dropped command still reset the parameter counter.
    cs_low(); send_byte(8'h55, 1'b1); cs_high();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    bit ok;
    cs_low();
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 258; i++) send_byte(8'(i * 7 + 3), 1'b1);
    cs_high();
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_byte();
    bit ok;
    int fe0;
    cs_low(); send_bits(8'hFF, 3, 1'b1);
    RESET_N = 1'b0; #1;
    n_checks++;
    if ({BYTE_VALID, BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX, LAST_CMD, FRAME_ERR, OVERFLOW} !== 28'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b/%h/%b/%h/%h/%b/%b required 0",
               BYTE_VALID, BYTE_OUT, BYTE_IS_DATA, BYTE_INDEX, LAST_CMD, FRAME_ERR, OVERFLOW);
    end
    m_pcnt = 8'd0; m_last = 8'd0; m_ovf = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    fe0 = fe_count;
    tick(6);
    send_byte(8'h36, 1'b0); cs_high();
    drain(ok);
    n_checks++;
    if (!ok || LAST_CMD !== 8'h36) begin
      n_fail++; $display("FAIL midreset_decode got %h pending %0d required 36", LAST_CMD, exp_q.size());
    end
    n_checks++;
    if (fe_count != fe0) begin n_fail++; $display("FAIL midreset_frame_err got %0d pulses required 0", fe_count - fe0); end
  endtask

  initial begin
    test_reset();
    test_single_cmd();
    test_cmd_params();
    test_split_frames();
    test_abort();
    test_backpressure();
    test_saturation();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
